gpsreceiver2_capture: RTL
=========================

Name: gpsreceiver2_capture

Overview:
- Upstream stage of the GPS receiver sample buffer; runs entirely in the gps_rec_clk domain.
- Takes the 2-bit sign/magnitude sample stream from the RF front-end and packs four samples per byte.
- Writes the bytes sequentially into the 2048-byte receive buffer through its byte-wide write port (rxb0_dat/rxb0_adr/rxb0_we).
- Supports one-shot captures of programmable length and continuous ring-buffer capture. Control inputs arrive already synchronised into gps_rec_clk.

Parameters:
- ADR_W, 11, byte address width of the receive buffer (depth 2^ADR_W = 2048 bytes).

Ports:
- gps_rec_clk  in  1  capture clock, front-end sample clock.
- gps_rec_rst  in  1  asynchronous active-high reset.
- gps_sign  in  1  sample sign bit.
- gps_mag  in  1  sample magnitude bit.
- sample_en  in  1  qualifies gps_sign/gps_mag this cycle (decimation strobe).
- start  in  1  single-cycle pulse: begin a capture.
- stop  in  1  single-cycle pulse: abort or end a capture.
- continuous  in  1  1 = ring mode, 0 = one-shot; sampled at start.
- cap_len  in  ADR_W+1  one-shot length in bytes; 0 means 2048; sampled at start.
- rxb0_dat  out  8  byte to buffer.
- rxb0_adr  out  ADR_W  byte address.
- rxb0_we  out  1  byte write strobe.
- busy  out  1  capture in progress.
- done  out  1  one-cycle pulse when a capture terminates.
- wr_ptr  out  ADR_W  address of the next byte to be written.
- wrap_cnt  out  16  ring-mode wrap counter, saturating.

Behaviour:
- Reset (async, active-high): state IDLE; all outputs 0; packing shift register and sample counter cleared.
- Sample code: s = {gps_sign, gps_mag}. Packing is MSB-first: byte = {s0, s1, s2, s3}, s0 being the earliest qualified sample.
- Each qualified sample (sample_en=1 in CAPTURE) shifts into the pack register. On the 4th sample, the registered outputs in the next cycle are rxb0_dat = packed byte, rxb0_adr = wr_ptr, rxb0_we = 1 (one-cycle latency from the 4th sample). wr_ptr increments modulo 2^ADR_W in the same cycle.
- rxb0_we is high for exactly one cycle per byte. Back-to-back bytes occur at most every 4 cycles.
- FSM states:
  - IDLE: busy=0. On start, latch continuous and cap_len (0 maps to 2048), clear wr_ptr, the sample counter and wrap_cnt, then go to CAPTURE. busy rises on the cycle after start.
  - CAPTURE: busy=1. Pack and write as above.
    - One-shot: after the byte that brings bytes_written to the latched length is written, go to DONE.
    - Ring: wr_ptr wraps from 2047 to 0; wrap_cnt increments on each wrap and saturates at 0xFFFF. Ring mode runs until stop.
    - stop: go to DONE. Any partial byte (fewer than 4 samples) is discarded, and no write is issued for it.
  - DONE: done=1 for one cycle, then go to IDLE. wr_ptr and wrap_cnt hold their values until the next start.
- Simultaneous events:
  - start while busy is ignored.
  - stop in IDLE or DONE is ignored.
  - start and stop in the same cycle in IDLE: start wins. In CAPTURE: stop wins.
  - stop in the same cycle as the 4th sample: the byte is still written, then the FSM goes to DONE.
  - One-shot length reached in the same cycle as stop: a single DONE and a single done pulse.
- sample_en=0 cycles freeze the packer. Samples are ignored outside CAPTURE.
- Reset asserted mid-capture: immediate return to IDLE, no done pulse, rxb0_we deasserts asynchronously.

Decomposition:
- Shared package gpsreceiver2_pkg holds:
  - state encoding (IDLE, CAPTURE, DONE);
  - RXB_ADR_W = 11 and RXB_DEPTH = 2048;
  - SAMPLES_PER_BYTE = 4.
- One natural sub-module: gpsreceiver2_packer. It takes the 2-bit sample shift register plus the 2-bit sample counter, and outputs the byte and a byte_valid strobe. The FSM, address and length counters and wrap counter stay in the top level.

Test Plan:
- One-shot, cap_len=4, sample_en always 1, samples s0..s15 = 3,2,1,0 repeated → four writes with rxb0_dat=0xE4 at addresses 0..3, each write one cycle after the 4th sample; done pulses once; wr_ptr=4; busy falls.
- cap_len=0 one-shot → exactly 2048 writes at addresses 0..2047, no wrap, wrap_cnt=0, a single done pulse.
- Ring mode, run 5000 bytes then stop → addresses wrap 2047→0; wrap_cnt=2; wr_ptr=5000 mod 2048=904; done pulses once.
- stop after 2 samples of a byte → no write for the partial byte; a subsequent start begins at address 0 with an empty packer (next byte = 4 fresh samples).
- sample_en toggling 1,0,0,1,… with start pulsed during CAPTURE → only qualified samples are packed; start is ignored; start+stop in the same IDLE cycle starts a capture.
- Reset asserted mid-byte during a write cycle → rxb0_we, busy, done, wr_ptr and wrap_cnt go to 0 immediately; after release the block is in IDLE and no done pulse occurs.

Source files
------------

// File: rtl/gpsreceiver2_pkg.sv
// Shared definitions for the GPS receiver capture path: FSM encoding,
// receive-buffer geometry and sample packing ratio.
package gpsreceiver2_pkg;

    localparam int RXB_ADR_W        = 11;
    localparam int RXB_DEPTH        = 2048;
    localparam int SAMPLES_PER_BYTE = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/gpsreceiver2_capture_if.sv
// Byte-wide write port into the receive buffer.
interface gpsreceiver2_capture_if #(
    parameter int ADR_W = 11
);
    logic [7:0]       rxb0_dat;
    logic [ADR_W-1:0] rxb0_adr;
    logic             rxb0_we;

    modport master (output rxb0_dat, output rxb0_adr, output rxb0_we);
    modport slave  (input  rxb0_dat, input  rxb0_adr, input  rxb0_we);
endinterface

// File: rtl/gpsreceiver2_packer.sv
// Combinational packer: shifts one 2-bit sample into the pack register and
// flags the sample that completes a byte (MSB-first, earliest sample on top).
module gpsreceiver2_packer
    import gpsreceiver2_pkg::*;
(
    input  logic [1:0] sample_i,
    input  logic       sample_vld_i,
    input  logic [5:0] shreg_i,
    input  logic [1:0] cnt_i,
    output logic [5:0] shreg_o,
    output logic [1:0] cnt_o,
    output logic [7:0] byte_o,
    output logic       byte_valid_o
);

    // Advance the pack register and sample counter on each qualified sample
    always_comb begin
        shreg_o      = shreg_i;
        cnt_o        = cnt_i;
        byte_o       = {shreg_i, sample_i};
        byte_valid_o = 1'b0;
        if (sample_vld_i) begin
            shreg_o      = {shreg_i[3:0], sample_i};
            cnt_o        = cnt_i + 2'd1;
            byte_valid_o = (cnt_i == 2'(SAMPLES_PER_BYTE - 1));
        end
    end

endmodule

// File: rtl/gpsreceiver2_capture.sv
// GPS sample capture: packs 2-bit sign/magnitude samples four per byte and
// writes them sequentially into the receive buffer, one-shot or ring mode.
module gpsreceiver2_capture
    import gpsreceiver2_pkg::*;
#(
    parameter int ADR_W = RXB_ADR_W
) (
    input  logic                   gps_rec_clk,
    input  logic                   gps_rec_rst,
    input  logic                   gps_sign,
    input  logic                   gps_mag,
    input  logic                   sample_en,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   continuous,
    input  logic [ADR_W:0]         cap_len,
    gpsreceiver2_capture_if.master rxb,
    output logic                   busy,
    output logic                   done,
    output logic [ADR_W-1:0]       wr_ptr,
    output logic [15:0]            wrap_cnt
);

    state_t           state_q, state_d;
    logic             cont_q, cont_d;
    logic [ADR_W:0]   len_q, len_d;
    logic [ADR_W:0]   bytes_q, bytes_d;
    logic [ADR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [15:0]      wrap_q, wrap_d;
    logic [5:0]       shreg_q, shreg_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [7:0]       dat_q, dat_d;
    logic [ADR_W-1:0] adr_q, adr_d;
    logic             we_q, we_d;

    logic [5:0]       pk_shreg;
    logic [1:0]       pk_cnt;
    logic [7:0]       pk_byte;
    logic             pk_valid;
    logic             sample_vld;
    logic [ADR_W:0]   bytes_inc;

    // Samples only count while capturing
    assign sample_vld = sample_en && (state_q == ST_CAPTURE);
    assign bytes_inc  = bytes_q + (ADR_W+1)'(1);

    gpsreceiver2_packer u_packer (
        .sample_i     ({gps_sign, gps_mag}),
        .sample_vld_i (sample_vld),
        .shreg_i      (shreg_q),
        .cnt_i        (cnt_q),
        .shreg_o      (pk_shreg),
        .cnt_o        (pk_cnt),
        .byte_o       (pk_byte),
        .byte_valid_o (pk_valid)
    );

    // Next-state logic: FSM transitions, write generation, pointer and wrap counting
    always_comb begin
        state_d  = state_q;
        cont_d   = cont_q;
        len_d    = len_q;
        bytes_d  = bytes_q;
        wr_ptr_d = wr_ptr_q;
        wrap_d   = wrap_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        dat_d    = dat_q;
        adr_d    = adr_q;
        we_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // start wins over a coincident stop; stop alone is ignored here
                if (start) begin
                    state_d  = ST_CAPTURE;
                    cont_d   = continuous;
                    len_d    = (cap_len == '0) ? (ADR_W+1)'(1 << ADR_W) : cap_len;
                    bytes_d  = '0;
                    wr_ptr_d = '0;
                    wrap_d   = '0;
                    shreg_d  = '0;
                    cnt_d    = '0;
                end
            end
            ST_CAPTURE: begin
                shreg_d = pk_shreg;
                cnt_d   = pk_cnt;
                if (pk_valid) begin
                    we_d     = 1'b1;
                    dat_d    = pk_byte;
                    adr_d    = wr_ptr_q;
                    wr_ptr_d = wr_ptr_q + ADR_W'(1);
                    bytes_d  = bytes_inc;
                    if (cont_q && (wr_ptr_q == '1) && (wrap_q != 16'hFFFF))
                        wrap_d = wrap_q + 16'd1;
                    if (!cont_q && (bytes_inc == len_q))
                        state_d = ST_DONE;
                end
                // stop ends the capture; a completing byte above is still written
                if (stop)
                    state_d = ST_DONE;
                // leaving capture drops any partial byte
                if (state_d == ST_DONE) begin
                    shreg_d = '0;
                    cnt_d   = '0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers, all cleared by the asynchronous reset
    always_ff @(posedge gps_rec_clk or posedge gps_rec_rst) begin
        if (gps_rec_rst) begin
            state_q  <= ST_IDLE;
            cont_q   <= 1'b0;
            len_q    <= '0;
            bytes_q  <= '0;
            wr_ptr_q <= '0;
            wrap_q   <= '0;
            shreg_q  <= '0;
            cnt_q    <= '0;
            dat_q    <= '0;
            adr_q    <= '0;
            we_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cont_q   <= cont_d;
            len_q    <= len_d;
            bytes_q  <= bytes_d;
            wr_ptr_q <= wr_ptr_d;
            wrap_q   <= wrap_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            dat_q    <= dat_d;
            adr_q    <= adr_d;
            we_q     <= we_d;
        end
    end

    assign rxb.rxb0_dat = dat_q;
    assign rxb.rxb0_adr = adr_q;
    assign rxb.rxb0_we  = we_q;
    assign busy         = (state_q == ST_CAPTURE);
    assign done         = (state_q == ST_DONE);
    assign wr_ptr       = wr_ptr_q;
    assign wrap_cnt     = wrap_q;

endmodule
